// File: rtl/button_gesture_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_gesture_decoder_pkg
// Description : Shared definitions for the button gesture decoder. Holds the
//               FSM state encoding, the default 25 MHz timing constants and
//               reduced timing values for fast simulation.
// Revision    : 1.0 - initial release
// ============================================================================
package button_gesture_decoder_pkg;

  // FSM state encoding (3-bit)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_PRESS2    = 3'd4
  } state_e;

  // Defaults for a 25 MHz board clock: 0.5 s long press, 0.2 s double gap
  localparam int c_DEF_LONG_CYCLES = 12500000;
  localparam int c_DEF_GAP_CYCLES  = 5000000;
  localparam int c_DEF_CNT_WIDTH   = 24;

  // Reduced values for simulation
  localparam int c_SIM_LONG_CYCLES = 8;
  localparam int c_SIM_GAP_CYCLES  = 4;
  localparam int c_SIM_CNT_WIDTH   = 4;

endpackage : button_gesture_decoder_pkg
`default_nettype wire

// File: rtl/button_gesture_decoder_timer.sv
`default_nettype none
// ============================================================================
// Module      : gesture_timer
// Description : Gesture duration counter. Synchronous clear has priority
//               over enable; the counter holds when not enabled. Provides
//               terminal-count flags for the long-press and gap windows.
// Ports       : i_Clk      - clock
//               i_Rst      - synchronous active-high reset
//               i_Clr      - synchronous clear (state transition)
//               i_En       - count enable (timed state held)
//               o_Long_Tc  - count == LONG_CYCLES-1
//               o_Gap_Tc   - count == GAP_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module gesture_timer
  import button_gesture_decoder_pkg::*;
#(
  parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
  parameter int LONG_CYCLES = c_DEF_LONG_CYCLES,
  parameter int GAP_CYCLES  = c_DEF_GAP_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Long_Tc,
  output logic o_Gap_Tc
);

  localparam logic [CNT_WIDTH-1:0] c_LONG_TC = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_GAP_TC  = CNT_WIDTH'(GAP_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clr) begin
      count_q <= '0;
    end else if (i_En) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_Long_Tc = (count_q == c_LONG_TC);
  assign o_Gap_Tc  = (count_q == c_GAP_TC);

endmodule : gesture_timer
`default_nettype wire

// File: rtl/button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_gesture_decoder
// Description : Classifies debounced switch presses as short press, long
//               press or double click and emits a one-cycle pulse for each.
// Ports       : i_Clk          - system clock
//               i_Rst          - synchronous active-high reset
//               i_Switch       - debounced switch level, 1 = pressed
//               o_Short_Pulse  - single short press completed
//               o_Long_Pulse   - press held LONG_CYCLES
//               o_Double_Pulse - double click completed
//               o_Pressed      - registered copy of i_Switch
//               o_Busy         - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module button_gesture_decoder
  import button_gesture_decoder_pkg::*;
#(
  parameter int LONG_CYCLES = c_DEF_LONG_CYCLES,
  parameter int GAP_CYCLES  = c_DEF_GAP_CYCLES,
  parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Short_Pulse,
  output logic o_Long_Pulse,
  output logic o_Double_Pulse,
  output logic o_Pressed,
  output logic o_Busy
);

  state_e state_q, state_d;
  logic   long_d, short_d, double_d;
  logic   timer_en, timer_clr;
  logic   long_tc, gap_tc;

  gesture_timer #(
    .CNT_WIDTH   (CNT_WIDTH),
    .LONG_CYCLES (LONG_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clr     (timer_clr),
    .i_En      (timer_en),
    .o_Long_Tc (long_tc),
    .o_Gap_Tc  (gap_tc)
  );

  // Next-state and pulse decode. Only PRESS1 and WAIT_GAP are timed, so the
  // counter is frozen elsewhere and can never wrap.
  always_comb begin
    state_d  = state_q;
    long_d   = 1'b0;
    short_d  = 1'b0;
    double_d = 1'b0;
    timer_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Switch) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        timer_en = 1'b1;
        if (!i_Switch) begin
          state_d = ST_WAIT_GAP;
        end else if (long_tc) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!i_Switch) state_d = ST_IDLE;
      end
      ST_WAIT_GAP: begin
        timer_en = 1'b1;
        // A second press beats the gap terminal count on the same edge
        if (i_Switch) begin
          state_d = ST_PRESS2;
        end else if (gap_tc) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!i_Switch) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every state change restarts the timer from zero
  assign timer_clr = (state_d != state_q);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q        <= ST_IDLE;
      o_Short_Pulse  <= 1'b0;
      o_Long_Pulse   <= 1'b0;
      o_Double_Pulse <= 1'b0;
      o_Pressed      <= 1'b0;
      o_Busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      o_Short_Pulse  <= short_d;
      o_Long_Pulse   <= long_d;
      o_Double_Pulse <= double_d;
      o_Pressed      <= i_Switch;
      o_Busy         <= (state_d != ST_IDLE);
    end
  end

endmodule : button_gesture_decoder
`default_nettype wire

// File: tb/tb_button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_gesture_decoder
// Description : Self-checking bench for button_gesture_decoder using the
//               reduced timing values (LONG=8, GAP=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_gesture_decoder;
  import button_gesture_decoder_pkg::*;

  localparam int L = c_SIM_LONG_CYCLES;
  localparam int G = c_SIM_GAP_CYCLES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sw;
  logic sp, lp, dp, pr, bz;

  button_gesture_decoder #(
    .LONG_CYCLES (L),
    .GAP_CYCLES  (G),
    .CNT_WIDTH   (c_SIM_CNT_WIDTH)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Switch       (sw),
    .o_Short_Pulse  (sp),
    .o_Long_Pulse   (lp),
    .o_Double_Pulse (dp),
    .o_Pressed      (pr),
    .o_Busy         (bz)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the next edge, then sample 1 ns after that edge
  task automatic step(input logic s, input logic r);
    sw  = s;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Reference model: classifies gestures from run lengths of the
  // sampled switch level rather than from a state machine.
  // ------------------------------------------------------------------
  int   m_run_len;
  logic m_run_val;
  bit   m_has_prev;     // a completed high run exists since reset
  int   m_prev_len;     // length of that high run
  bit   m_prev_second;  // it was the second press of a double click
  bit   m_cur_second;   // current/most recent high run is a second press

  task automatic model_step(input logic s, input logic r,
                            output logic el, output logic es, output logic ed,
                            output logic eb, output logic ep);
    bit pending;
    if (r) begin
      m_run_len = 0; m_run_val = 1'b0; m_has_prev = 0;
      m_prev_len = 0; m_prev_second = 0; m_cur_second = 0;
      el = 0; es = 0; ed = 0; eb = 0; ep = 0;
      return;
    end
    if (m_run_len == 0 || s != m_run_val) begin
      if (m_run_val && m_run_len > 0) begin
        m_has_prev    = 1;
        m_prev_len    = m_run_len;
        m_prev_second = m_cur_second;
      end
      // A new press is a second press if it follows a short first press
      // within G low samples.
      if (s)
        m_cur_second = m_has_prev && !m_prev_second && (m_prev_len <= L)
                       && (m_run_len > 0) && (m_run_len <= G);
      m_run_val = s;
      m_run_len = 1;
    end else begin
      m_run_len++;
    end
    pending = m_has_prev && !m_prev_second && (m_prev_len <= L);
    el = s && !m_cur_second && (m_run_len == L + 1);
    es = !s && pending && (m_run_len == G + 1);
    ed = !s && (m_run_len == 1) && m_has_prev && m_prev_second;
    eb = s ? 1'b1 : (pending && (m_run_len <= G));
    ep = s;
  endtask

  // ------------------------------------------------------------------
  // Directed vectors: high intervals, expected pulse edges (-1 = none)
  // and the edge at which o_Busy must first be low again.
  // ------------------------------------------------------------------
  typedef struct {
    int h1s, h1e, h2s, h2e;
    int long_e, short_e, dbl_e, idle_e;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic el, es, ed, eb, ep;
    logic cur;
    bit   rr;
    int   remaining;
    int   long_cnt;
    logic s;

    vecs[0] = '{10, 12, -1, -1, -1, 17, -1, 17};  // short press
    vecs[1] = '{10, 18, -1, -1, 18, -1, -1, 19};  // long exactly at boundary
    vecs[2] = '{10, 17, -1, -1, -1, 22, -1, 22};  // one short of long
    vecs[3] = '{10, 11, 14, 15, -1, -1, 16, 16};  // double click
    vecs[4] = '{10, 11, 16, 17, -1, -1, 18, 18};  // second press on gap TC

    sw = 1'b0; rst = 1'b1;
    step(0, 1);
    step(0, 1);
    check("reset short", sp, 0);
    check("reset long", lp, 0);
    check("reset double", dp, 0);
    check("reset pressed", pr, 0);
    check("reset busy", bz, 0);

    for (int v = 0; v < 5; v++) begin
      step(0, 1);
      for (int e = 0; e < 40; e++) begin
        s = ((e >= vecs[v].h1s) && (e <= vecs[v].h1e)) ||
            ((e >= vecs[v].h2s) && (e <= vecs[v].h2e));
        step(s, 0);
        check($sformatf("v%0d long e%0d", v, e), lp, e == vecs[v].long_e);
        check($sformatf("v%0d short e%0d", v, e), sp, e == vecs[v].short_e);
        check($sformatf("v%0d double e%0d", v, e), dp, e == vecs[v].dbl_e);
        check($sformatf("v%0d pressed e%0d", v, e), pr, s);
        if (e == vecs[v].idle_e - 1) check($sformatf("v%0d busy e%0d", v, e), bz, 1);
        if (e == vecs[v].idle_e)     check($sformatf("v%0d idle e%0d", v, e), bz, 0);
      end
    end

    // Reset mid-press, switch still held afterwards
    step(0, 1);
    for (int e = 0; e < 14; e++) step(e >= 10, 0);
    step(1, 1);  // edge 14
    check("midrst short", sp, 0);
    check("midrst long", lp, 0);
    check("midrst double", dp, 0);
    check("midrst pressed", pr, 0);
    check("midrst busy", bz, 0);
    for (int e = 15; e < 30; e++) begin
      step(1, 0);
      check($sformatf("midrst long e%0d", e), lp, e == 23);
      check($sformatf("midrst busy e%0d", e), bz, 1);
    end
    step(0, 0);
    check("midrst release long", lp, 0);
    check("midrst release short", sp, 0);

    // Continuous hold for 100 cycles
    step(0, 1);
    long_cnt = 0;
    for (int e = 0; e < 100; e++) begin
      step(1, 0);
      if (lp) long_cnt++;
      check($sformatf("hold pressed c%0d", e), pr, 1);
      check($sformatf("hold short c%0d", e), sp, 0);
    end
    check_int("hold long count", long_cnt, 1);
    step(0, 0);
    check("hold release pressed", pr, 0);
    check("hold release short", sp, 0);
    check("hold release double", dp, 0);
    check("hold release busy", bz, 0);

    // Randomised runs checked against the reference model
    model_step(0, 1, el, es, ed, eb, ep);
    step(0, 1);
    cur = 1'b0;
    remaining = 5;
    for (int c = 0; c < 3000; c++) begin
      if (remaining == 0) begin
        cur = ~cur;
        remaining = int'($urandom_range(1, 12));
      end
      remaining--;
      rr = ($urandom_range(0, 199) == 0);
      model_step(cur, rr, el, es, ed, eb, ep);
      step(cur, rr);
      check($sformatf("rand long c%0d", c), lp, el);
      check($sformatf("rand short c%0d", c), sp, es);
      check($sformatf("rand double c%0d", c), dp, ed);
      check($sformatf("rand busy c%0d", c), bz, eb);
      check($sformatf("rand pressed c%0d", c), pr, ep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_gesture_decoder
`default_nettype wire
